// File: rtl/lif_spike_encoder.sv
// lif_spike_encoder: leaky integrate-and-fire spike encoder.
// Each accepted sample is added to a leaking membrane potential. When the
// potential reaches THRESHOLD, the block emits a one-cycle spike, clears the
// potential and ignores input for REFRAC cycles.
// Optional feature macro: SPIKE_COUNT_EN adds a saturating 16-bit spike_count.
module lif_spike_encoder #(
  parameter int WIDTH      = 8,
  parameter int THRESHOLD  = 128,
  parameter int LEAK_SHIFT = 3,
  parameter int REFRAC     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             spike,
  output logic [WIDTH-1:0] mem_out
`ifdef SPIKE_COUNT_EN
  ,
  output logic [15:0]      spike_count
`endif
);

  typedef enum logic {
    INTEGRATE  = 1'b0,
    REFRACTORY = 1'b1
  } state_t;

  localparam logic [WIDTH:0] SAT_MAX  = {1'b0, {WIDTH{1'b1}}};
  localparam logic [WIDTH:0] THR      = (WIDTH+1)'(THRESHOLD);
  localparam logic [7:0]     REFRAC_L = 8'(REFRAC);

  state_t           state;
  state_t           state_nxt;
  logic [7:0]       ref_cnt;
  logic             accept;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] nxt_mem;
  logic             fire;

  // Leak, integrate and saturate; fire when the saturated value meets threshold
  always_comb begin
    accept  = in_valid && in_ready;
    sum     = {1'b0, mem_out} - {1'b0, (mem_out >> LEAK_SHIFT)}
              + (accept ? {1'b0, in_data} : '0);
    nxt_mem = (sum > SAT_MAX) ? '1 : sum[WIDTH-1:0];
    fire    = (state == INTEGRATE) && ({1'b0, nxt_mem} >= THR);
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= INTEGRATE;
    else     state <= state_nxt;
  end

  // Next-state logic; with REFRAC of zero a spike never leaves INTEGRATE
  always_comb begin
    state_nxt = state;
    case (state)
      INTEGRATE:  if (fire && (REFRAC_L != 8'd0)) state_nxt = REFRACTORY;
      REFRACTORY: if (ref_cnt == 8'd1)            state_nxt = INTEGRATE;
      default:                                    state_nxt = INTEGRATE;
    endcase
  end

  // Output logic: ready depends on state only
  always_comb begin
    in_ready = (state == INTEGRATE);
  end

  // Membrane, spike pulse and refractory counter
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_out <= '0;
      spike   <= 1'b0;
      ref_cnt <= '0;
    end else if (state == INTEGRATE) begin
      if (fire) begin
        mem_out <= '0;
        spike   <= 1'b1;
        ref_cnt <= REFRAC_L;
      end else begin
        mem_out <= nxt_mem;
        spike   <= 1'b0;
      end
    end else begin
      mem_out <= '0;
      spike   <= 1'b0;
      ref_cnt <= ref_cnt - 8'd1;
    end
  end

`ifdef SPIKE_COUNT_EN
  // Saturating count of spike edges since reset
  always_ff @(posedge clk) begin
    if (rst)                                  spike_count <= '0;
    else if (fire && (spike_count != '1))     spike_count <= spike_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_lif_spike_encoder.sv
// tb_lif_spike_encoder: checks two encoder configurations (defaults, and a
// saturating no-refractory variant) against a behavioural model, with
// directed literal checks followed by randomized stimulus.
module tb_lif_spike_encoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = '0;

  logic       rdy_a, spk_a, rdy_b, spk_b;
  logic [7:0] mem_a, mem_b;
`ifdef SPIKE_COUNT_EN
  logic [15:0] cnt_a, cnt_b;
`endif

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  lif_spike_encoder #(.WIDTH(8), .THRESHOLD(128), .LEAK_SHIFT(3), .REFRAC(4)) u_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy_a), .spike(spk_a), .mem_out(mem_a)
`ifdef SPIKE_COUNT_EN
    , .spike_count(cnt_a)
`endif
  );

  lif_spike_encoder #(.WIDTH(8), .THRESHOLD(255), .LEAK_SHIFT(7), .REFRAC(0)) u_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy_b), .spike(spk_b), .mem_out(mem_b)
`ifdef SPIKE_COUNT_EN
    , .spike_count(cnt_b)
`endif
  );

  // Behavioural model: potential, remaining blocked cycles, last spike, count
  int th[2] = '{128, 255};
  int ls[2] = '{3, 7};
  int rf[2] = '{4, 0};
  int m_mem[2] = '{0, 0};
  int m_rem[2] = '{0, 0};
  int m_spk[2] = '{0, 0};
  int m_cnt[2] = '{0, 0};

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      int n;
      if (rst) begin
        m_mem[i] <= 0; m_rem[i] <= 0; m_spk[i] <= 0; m_cnt[i] <= 0;
      end else if (m_rem[i] > 0) begin
        m_mem[i] <= 0; m_rem[i] <= m_rem[i] - 1; m_spk[i] <= 0;
      end else begin
        n = m_mem[i] - m_mem[i] / (1 << ls[i]) + (in_valid ? int'(in_data) : 0);
        if (n > 255) n = 255;
        if (n >= th[i]) begin
          m_mem[i] <= 0; m_spk[i] <= 1; m_rem[i] <= rf[i];
          m_cnt[i] <= (m_cnt[i] < 65535) ? m_cnt[i] + 1 : 65535;
        end else begin
          m_mem[i] <= n; m_spk[i] <= 0;
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of both instances against the model
  always @(negedge clk) begin
    if (chk_en) begin
      check("a.mem",   int'(mem_a), m_mem[0]);
      check("a.spike", int'(spk_a), m_spk[0]);
      check("a.ready", int'(rdy_a), (m_rem[0] == 0) ? 1 : 0);
      check("b.mem",   int'(mem_b), m_mem[1]);
      check("b.spike", int'(spk_b), m_spk[1]);
      check("b.ready", int'(rdy_b), (m_rem[1] == 0) ? 1 : 0);
`ifdef SPIKE_COUNT_EN
      check("a.count", int'(cnt_a), m_cnt[0]);
      check("b.count", int'(cnt_b), m_cnt[1]);
`endif
    end
  end

  task automatic step(input bit r, input bit v, input int d);
    rst      = r;
    in_valid = v;
    in_data  = 8'(d);
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset for two cycles
    step(1, 0, 0);
    step(1, 0, 0);
    chk_en = 1'b1;
    check("rst.mem",   int'(mem_a), 0);
    check("rst.spike", int'(spk_a), 0);
    check("rst.ready", int'(rdy_a), 1);

    // Integrate and fire with 64 per cycle
    step(0, 1, 64);  check("iaf.mem1", int'(mem_a), 64);
    step(0, 1, 64);  check("iaf.mem2", int'(mem_a), 120);
    step(0, 1, 64);  check("iaf.spike", int'(spk_a), 1);
    check("iaf.mem0", int'(mem_a), 0);
    check("iaf.rdy0", int'(rdy_a), 0);
    for (int k = 0; k < 3; k++) begin
      step(0, 1, 64);
      check("iaf.rdy_low", int'(rdy_a), 0);
      check("iaf.nospk", int'(spk_a), 0);
    end
    step(0, 1, 64);  check("iaf.rdy_back", int'(rdy_a), 1);
    check("iaf.mem_dropped", int'(mem_a), 0);
    step(0, 1, 64);  check("iaf.reaccept", int'(mem_a), 64);

    // Leak decay after a single sample
    step(1, 0, 0);
    step(0, 1, 100); check("leak.100", int'(mem_a), 100);
    step(0, 0, 0);   check("leak.88", int'(mem_a), 88);
    step(0, 0, 0);   check("leak.77", int'(mem_a), 77);
    step(0, 0, 0);   check("leak.68", int'(mem_a), 68);
    step(0, 0, 0);   check("leak.60", int'(mem_a), 60);

    // Saturation and back-to-back spikes on the second instance
    step(1, 0, 0);
    step(0, 1, 250); check("sat.mem250", int'(mem_b), 250);
    check("sat.nospk", int'(spk_b), 0);
    step(0, 1, 250); check("sat.spike", int'(spk_b), 1);
    check("sat.mem0", int'(mem_b), 0);
    check("sat.ready", int'(rdy_b), 1);
    step(0, 1, 255); check("b2b.spike", int'(spk_b), 1);

    // Reset during the refractory period
    step(1, 0, 0);
    step(0, 1, 200); check("rref.spike", int'(spk_a), 1);
    step(0, 0, 0);   check("rref.rdy_low", int'(rdy_a), 0);
    step(1, 0, 0);
    check("rref.ready", int'(rdy_a), 1);
    check("rref.mem", int'(mem_a), 0);
    check("rref.nospk", int'(spk_a), 0);
    step(0, 1, 200); check("rref.fire", int'(spk_a), 1);

    // Randomized traffic, occasional reset
    for (int k = 0; k < 3000; k++) begin
      step($urandom_range(0, 99) == 0, $urandom_range(0, 9) < 7,
           ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255))
                                       : int'($urandom_range(0, 80)));
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
